// File: rtl/counter_pkg.sv
// Shared types and limits for the down-timer family.
package counter_pkg;

  // FSM encoding for the down timer.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } timer_state_t;

  // Widest counter that the timer supports.
  localparam int TIMER_WIDTH_MAX = 16;

  // Smallest counter that the timer supports.
  localparam int TIMER_WIDTH_MIN = 2;

  // Report whether a counter of width w holds the value one.
  function automatic logic is_one(input logic [TIMER_WIDTH_MAX-1:0] value);
    return (value == {{(TIMER_WIDTH_MAX-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/down_count_core.sv
// Count register for the down timer: load, decrement or hold, with a flag
// that shows the next enabled decrement reaches zero.
module down_count_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic [WIDTH-1:0] count,
  output logic             zero_next
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_next_s;
  logic [TIMER_WIDTH_MAX-1:0] count_wide_s;

  // Select the next count; load wins over decrement, and the count never wraps.
  always_comb begin
    count_next_s = count_r;
    if (load_en) begin
      count_next_s = load_val;
    end else if (dec_en) begin
      if (count_r != ZERO_C) begin
        count_next_s = count_r - ONE_C;
      end else begin
        count_next_s = ZERO_C;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= ZERO_C;
    end else begin
      count_r <= count_next_s;
    end
  end

  // Zero-extend the count so the shared helper can test for one.
  always_comb begin
    count_wide_s = {TIMER_WIDTH_MAX{1'b0}};
    count_wide_s[WIDTH-1:0] = count_r;
  end

  assign count     = count_r;
  assign zero_next = is_one(count_wide_s);

endmodule

// File: rtl/four_bit_down_timer.sv
// Loadable down-counter / interval timer with one-shot and auto-reload modes.
// A load is taken over a valid/ready handshake; tc pulses for one cycle when
// the count reaches its terminal value.
module four_bit_down_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] Cout,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  timer_state_t     state_r;
  timer_state_t     state_next_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_next_s;
  logic             mode_r;
  logic             mode_next_s;
  logic             tc_r;
  logic             tc_next_s;
  logic             done_r;
  logic             busy_r;
  logic             ready_r;

  logic             core_load_s;
  logic [WIDTH-1:0] core_load_val_s;
  logic             core_dec_s;
  logic [WIDTH-1:0] count_s;
  logic             zero_next_s;

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .clear     (clear),
    .load_en   (core_load_s),
    .load_val  (core_load_val_s),
    .dec_en    (core_dec_s),
    .count     (count_s),
    .zero_next (zero_next_s)
  );

  // Next-state and datapath control; abort beats load, load beats counting.
  always_comb begin
    state_next_s    = state_r;
    reload_next_s   = reload_r;
    mode_next_s     = mode_r;
    tc_next_s       = 1'b0;
    core_load_s     = 1'b0;
    core_load_val_s = ZERO_C;
    core_dec_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (load_valid) begin
          reload_next_s   = load_value;
          mode_next_s     = auto_reload;
          core_load_s     = 1'b1;
          core_load_val_s = load_value;
          if (load_value != ZERO_C) begin
            state_next_s = RUN;
          end else begin
            // Zero-length one-shot, regardless of auto_reload.
            state_next_s = DONE;
            tc_next_s    = 1'b1;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      RUN: begin
        if (abort) begin
          state_next_s    = IDLE;
          core_load_s     = 1'b1;
          core_load_val_s = ZERO_C;
        end else if (enable) begin
          if (zero_next_s) begin
            tc_next_s = 1'b1;
            if (mode_r) begin
              // Periodic mode: restart so the period is exactly N enabled cycles.
              core_load_s     = 1'b1;
              core_load_val_s = reload_r;
              state_next_s    = RUN;
            end else begin
              core_dec_s   = 1'b1;
              state_next_s = DONE;
            end
          end else begin
            core_dec_s = 1'b1;
          end
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s    = IDLE;
        core_load_s     = 1'b1;
        core_load_val_s = ZERO_C;
      end
    endcase
  end

  // State, load context and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r  <= IDLE;
      reload_r <= ZERO_C;
      mode_r   <= 1'b0;
      tc_r     <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_next_s;
      reload_r <= reload_next_s;
      mode_r   <= mode_next_s;
      tc_r     <= tc_next_s;
      done_r   <= (state_next_s == DONE);
      busy_r   <= (state_next_s == RUN);
      ready_r  <= (state_next_s != RUN);
    end
  end

  assign Cout       = count_s;
  assign tc         = tc_r;
  assign done       = done_r;
  assign busy       = busy_r;
  assign load_ready = ready_r;

endmodule

// File: tb/tb_four_bit_down_timer.sv
// Directed bench for four_bit_down_timer: each step drives inputs, queues the
// expected post-edge outputs, then pops and compares after the edge.
module tb_four_bit_down_timer;

  logic       clk;
  logic       clear;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_value;
  logic       auto_reload;
  logic       enable;
  logic       abort;
  logic [3:0] Cout;
  logic       busy;
  logic       tc;
  logic       done;

  typedef struct packed {
    logic [3:0] cout;
    logic       tc;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  four_bit_down_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .clear       (clear),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .auto_reload (auto_reload),
    .enable      (enable),
    .abort       (abort),
    .Cout        (Cout),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, expv);
    end
  endtask

  // Drive one cycle of inputs, queue its expected result, and compare after the edge.
  task automatic step(input string name,
                      input logic c, input logic lv, input logic [3:0] val,
                      input logic ar, input logic en, input logic ab,
                      input logic [3:0] e_cout, input logic e_tc,
                      input logic e_busy, input logic e_done, input logic e_ready);
    exp_t e;
    exp_t got;
    clear       = c;
    load_valid  = lv;
    load_value  = val;
    auto_reload = ar;
    enable      = en;
    abort       = ab;
    e.cout = e_cout; e.tc = e_tc; e.busy = e_busy; e.done = e_done; e.ready = e_ready;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({name, ".Cout"},  int'(Cout),       int'(got.cout));
    chk({name, ".tc"},    int'(tc),         int'(got.tc));
    chk({name, ".busy"},  int'(busy),       int'(got.busy));
    chk({name, ".done"},  int'(done),       int'(got.done));
    chk({name, ".ready"}, int'(load_ready), int'(got.ready));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear = 1'b1; load_valid = 1'b0; load_value = 4'd0;
    auto_reload = 1'b0; enable = 1'b0; abort = 1'b0;
    #2;

    // 1. clear with random other inputs
    for (int i = 0; i < 2; i++)
      step("clr", 1'b1, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 2. one-shot N=5
    step("os_ld", 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 4; n >= 1; n--)
      step("os_cnt", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'(n), 1'b0, 1'b1, 1'b0, 1'b0);
    step("os_tc", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("os_hold", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 3. auto-reload N=3 for 12 enabled cycles
    step("ar_ld", 1'b0, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      step("ar_2", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      step("ar_1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      step("ar_tc", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    step("ar_abort", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4. enable gaps with N=4: 1,0,0,1,1,1
    step("gap_ld", 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap_e1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap_e0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap_e0", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap_e1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap_e1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("gap_tc", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    // 5. abort at Cout=1 with enable, then load_valid ignored during RUN
    step("ab_ld", 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ab_1", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("ab_hit", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("ab_idle", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("rl_ld", 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rl_rej", 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rl_rej2", 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rl_abort", 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6. zero-length load with auto_reload set, then clear mid-RUN at Cout=7
    step("z_ld", 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step("z_hold", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mx_ld", 1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int n = 14; n >= 7; n--)
      step("mx_cnt", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'(n), 1'b0, 1'b1, 1'b0, 1'b0);
    step("mid_clr", 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("post_clr", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
